sd_spi_burst_engine: RTL

// Parametrised SPI mode-0 master for the SD card slot, sitting between the 68K register decoder and the
// SD_CLK/SD_CMD/SD_DAT/SD_DAT3 pins. Sends single command bytes, or runs hardware burst reads (N x 0xFF

---
 rtl/sd_spi_burst_engine_if.sv | 40 ++++
 rtl/sd_spi_burst_engine.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sd_spi_burst_engine_if.sv
// CPU-side register bus and SD card pin bundle for the SPI burst engine.
interface sd_spi_burst_engine_if #(
    parameter int FIFO_AW = 4,
    parameter int BURST_W = 10
);
    logic               TX_VALID;
    logic [7:0]         TX_DATA;
    logic               TX_READY;
    logic               BURST_START;
    logic [BURST_W-1:0] BURST_LEN;
    logic               HIGH_SPEED;
    logic               CS_WE;
    logic               CS_LEVEL;
    logic [7:0]         RX_LAST;
    logic               RX_POP;
    logic [7:0]         RX_DATA;
    logic               RX_EMPTY;
    logic               RX_FULL;
    logic [FIFO_AW:0]   RX_COUNT;
    logic [BURST_W-1:0] BURST_LEFT;
    logic               BUSY;
    logic               SPI_CLK;
    logic               SPI_MOSI;
    logic               SPI_MISO;
    logic               SPI_CS;

    // Engine side
    modport slave (
        input  TX_VALID, TX_DATA, BURST_START, BURST_LEN, HIGH_SPEED, CS_WE, CS_LEVEL, RX_POP, SPI_MISO,
        output TX_READY, RX_LAST, RX_DATA, RX_EMPTY, RX_FULL, RX_COUNT, BURST_LEFT, BUSY,
               SPI_CLK, SPI_MOSI, SPI_CS
    );

    // CPU / card side
    modport master (
        output TX_VALID, TX_DATA, BURST_START, BURST_LEN, HIGH_SPEED, CS_WE, CS_LEVEL, RX_POP, SPI_MISO,
        input  TX_READY, RX_LAST, RX_DATA, RX_EMPTY, RX_FULL, RX_COUNT, BURST_LEFT, BUSY,
               SPI_CLK, SPI_MOSI, SPI_CS
    );
endinterface

// File: rtl/sd_spi_burst_engine.sv
// SPI mode-0 master for the SD slot: single command bytes or hardware burst reads
// of 0xFF bytes into an RX FIFO, with per-instance slow/fast clock dividers.
module sd_spi_burst_engine #(
    parameter int SLOW_DIV = 30,
    parameter int FAST_DIV = 1,
    parameter int DIV_W    = 5,
    parameter int FIFO_AW  = 4,
    parameter int BURST_W  = 10
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    sd_spi_burst_engine_if.slave  bus
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {IDLE, SHIFT, STALL} state_t;

    state_t             state;
    logic [7:0]         shreg;
    logic [7:0]         rxreg;
    logic [7:0]         rx_last;
    logic [DIV_W-1:0]   div_lat;
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0]         half_cnt;
    logic               burst_mode;
    logic [BURST_W-1:0] burst_left;
    logic               spi_clk;
    logic               cs;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic room;
    logic byte_end;
    logic push;
    logic accept;

    assign fifo_full  = (count == (FIFO_AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = bus.RX_POP && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the byte.
    assign room       = !fifo_full || pop;
    assign byte_end   = (state == SHIFT) && (div_cnt == '0) && (half_cnt == 4'd15);
    assign push       = burst_mode && room && (byte_end || (state == STALL));
    assign accept     = bus.TX_VALID || (bus.BURST_START && (bus.BURST_LEN != '0));

    // RX FIFO pointers and occupancy; push+pop together leaves the count unchanged.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // RX FIFO storage; received byte is held in rxreg until it is written.
    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr] <= rxreg;
    end

    // Transfer FSM: clock generation, bit shifting, byte completion and FIFO stall.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state      <= IDLE;
            shreg      <= 8'hFF;
            rx_last    <= 8'h00;
            div_lat    <= '0;
            div_cnt    <= '0;
            half_cnt   <= '0;
            burst_mode <= 1'b0;
            burst_left <= '0;
            spi_clk    <= 1'b0;
            cs         <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.CS_WE) cs <= bus.CS_LEVEL;
                    if (accept) begin
                        div_lat  <= bus.HIGH_SPEED ? DIV_W'(FAST_DIV) : DIV_W'(SLOW_DIV);
                        div_cnt  <= bus.HIGH_SPEED ? DIV_W'(FAST_DIV) : DIV_W'(SLOW_DIV);
                        half_cnt <= '0;
                        state    <= SHIFT;
                        if (bus.TX_VALID) begin
                            shreg      <= bus.TX_DATA;
                            burst_mode <= 1'b0;
                        end else begin
                            shreg      <= 8'hFF;
                            burst_mode <= 1'b1;
                            burst_left <= bus.BURST_LEN;
                        end
                    end
                end
                SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt  <= div_lat;
                        half_cnt <= half_cnt + 1'b1;
                        spi_clk  <= ~spi_clk;
                        if (!half_cnt[0]) begin
                            rxreg <= {rxreg[6:0], bus.SPI_MISO};
                        end else if (half_cnt != 4'd15) begin
                            shreg <= {shreg[6:0], 1'b1};
                        end else begin
                            // Last falling edge: MOSI returns high between bytes and while stalled.
                            shreg <= 8'hFF;
                            if (!burst_mode) begin
                                rx_last <= rxreg;
                                state   <= IDLE;
                            end else if (!room) begin
                                state <= STALL;
                            end else begin
                                burst_left <= burst_left - 1'b1;
                                if (burst_left == BURST_W'(1)) state <= IDLE;
                            end
                        end
                    end
                end
                STALL: begin
                    // half_cnt has wrapped to 0 and div_cnt is reloaded, so SHIFT resumes cleanly.
                    if (room) begin
                        burst_left <= burst_left - 1'b1;
                        state      <= (burst_left == BURST_W'(1)) ? IDLE : SHIFT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.TX_READY   = (state == IDLE);
    assign bus.BUSY       = (state != IDLE);
    assign bus.SPI_CLK    = spi_clk;
    assign bus.SPI_MOSI   = shreg[7];
    assign bus.SPI_CS     = cs;
    assign bus.RX_LAST    = rx_last;
    assign bus.RX_DATA    = mem[rd_ptr];
    assign bus.RX_EMPTY   = fifo_empty;
    assign bus.RX_FULL    = fifo_full;
    assign bus.RX_COUNT   = count;
    assign bus.BURST_LEFT = burst_left;
endmodule
